// File: rtl/txctrl_pkg.sv
// Shared types and constants for the UART-style transmit controller.
// Holds the FSM state encoding, configuration codes and frame geometry.
package txctrl_pkg;

  localparam int FRAME_W = 11;
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE2 = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    BITS_5 = 2'b00,
    BITS_6 = 2'b01,
    BITS_7 = 2'b10,
    BITS_8 = 2'b11
  } bits_e;

  function automatic logic [COUNT_W-1:0] data_bits(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO with wrap-around pointers and a synchronous active-low reset.
// Pushes while full and pops while empty are ignored.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // The extra pointer MSB separates the full and empty cases when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tx_ctrl.sv
// Transmit controller: queues bytes, builds serial frames and hands them to the shifter.
// Parity generation exists only when TXCTRL_PARITY_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a queued byte
// LOAD    | pop byte, build frame, strobe shifter next cycle
// WAIT    | frame in flight, waiting for a rising edge of i_Sh_Done
module tx_ctrl
  import txctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_Pclk,
  input  logic               i_Rst_n,
  input  logic               i_Valid,
  input  logic [7:0]         i_Data,
  output logic               o_Ready,
  input  logic [1:0]         i_Cfg_Bits,
  input  logic [1:0]         i_Cfg_Parity,
  input  logic               i_Cfg_Stop,
  output logic               o_Sh_Enable,
  output logic [FRAME_W-1:0] o_Sh_Data,
  output logic [COUNT_W-1:0] o_Sh_Count,
  input  logic               i_Sh_Done,
  output logic               o_Busy
);

  state_e              state_q, state_d;
  logic                rdy_q;
  logic                done_q;
  logic                sh_en_q;
  logic [FRAME_W-1:0]  sh_data_q, frame_d;
  logic [COUNT_W-1:0]  sh_count_q, count_d;
  logic [COUNT_W-1:0]  n_bits, par_len;
  logic                load, push;
  logic [7:0]          fifo_rdata;
  logic                fifo_full, fifo_empty;

  // rdy_q keeps o_Ready low for the cycle following a reset edge.
  assign o_Ready = rdy_q && !fifo_full;
  assign push    = i_Valid && o_Ready;
  assign o_Busy  = (state_q != ST_IDLE) || !fifo_empty;

  assign o_Sh_Enable = sh_en_q;
  assign o_Sh_Data   = sh_data_q;
  assign o_Sh_Count  = sh_count_q;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk_i   (i_Pclk),
    .rst_n_i (i_Rst_n),
    .push_i  (push),
    .pop_i   (load),
    .wdata_i (i_Data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef TXCTRL_PARITY_EN
  logic par_bit;
`else
  logic unused_cfg_parity;
  assign unused_cfg_parity = ^i_Cfg_Parity;
`endif

  always_comb begin
    n_bits     = data_bits(i_Cfg_Bits);
    frame_d    = '1;
    frame_d[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n_bits) frame_d[i+1] = fifo_rdata[i];
    end
    par_len = '0;
`ifdef TXCTRL_PARITY_EN
    par_bit = (i_Cfg_Parity == PAR_ODD);
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n_bits) par_bit = par_bit ^ fifo_rdata[i];
    end
    if ((i_Cfg_Parity == PAR_ODD) || (i_Cfg_Parity == PAR_EVEN)) begin
      par_len = 4'd1;
      for (int j = 6; j < FRAME_W; j++) begin
        if (4'(j) == n_bits + 4'd1) frame_d[j] = par_bit;
      end
    end
`endif
    // Stop bits are already ones in the default fill; only the count changes.
    count_d = 4'd1 + n_bits + par_len + (i_Cfg_Stop ? 4'd2 : 4'd1);
    if (count_d > 4'(FRAME_W)) count_d = 4'(FRAME_W);
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (i_Sh_Done && !done_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // done_q follows i_Sh_Done every cycle, so a level held high through LOAD never looks like an edge.
  always_ff @(posedge i_Pclk) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
      sh_en_q    <= 1'b0;
      sh_data_q  <= '1;
      sh_count_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      done_q  <= i_Sh_Done;
      sh_en_q <= load;
      if (load) begin
        sh_data_q  <= frame_d;
        sh_count_q <= count_d;
      end
    end
  end

endmodule
